// File: rtl/axis_video_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axis_video_pkg
// Brief   : Pixel-processing mode encodings and default geometry constants.
// Revision: 1.0 - initial release
// ============================================================================
package axis_video_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_OFS  = 2'd2,
        MODE_THR  = 2'd3
    } mode_e;

    localparam int c_DEFAULT_CW       = 8;
    localparam int c_DEFAULT_CHANNELS = 3;

endpackage
`default_nettype wire

// File: rtl/axis_video_pixel_proc_if.sv
`default_nettype none
// ============================================================================
// Module  : axis_video_pixel_proc_if
// Brief   : AXI4-Stream video bus (tuser = start of frame, tlast = end of line).
// Revision: 1.0 - initial release
// ============================================================================
interface axis_video_pixel_proc_if
    import axis_video_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_CW * c_DEFAULT_CHANNELS
) ();

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, output tvalid, input tready, output tlast, output tuser);
    modport slave  (input tdata, input tvalid, output tready, input tlast, input tuser);

endinterface
`default_nettype wire

// File: rtl/axis_video_chan_op.sv
`default_nettype none
// ============================================================================
// Module  : axis_video_chan_op
// Brief   : Combinational per-channel pass / invert / offset-clamp / threshold.
// Revision: 1.0 - initial release
// ============================================================================
module axis_video_chan_op
    import axis_video_pkg::*;
#(
    parameter int CW = c_DEFAULT_CW
) (
    input  logic [CW-1:0] i_pix,
    input  mode_e         i_mode,
    input  logic [CW:0]   i_offset,
    input  logic [CW-1:0] i_threshold,
    output logic [CW-1:0] o_pix
);

    logic [CW+1:0] w_sum;

    always_comb begin
        // Two guard bits: bit CW+1 flags a negative result, bit CW an overflow.
        w_sum = {2'b00, i_pix} + {i_offset[CW], i_offset};
        o_pix = i_pix;
        case (i_mode)
            MODE_PASS: o_pix = i_pix;
            MODE_INV:  o_pix = ~i_pix;
            MODE_OFS: begin
                if (w_sum[CW+1])
                    o_pix = '0;
                else if (w_sum[CW])
                    o_pix = '1;
                else
                    o_pix = w_sum[CW-1:0];
            end
            MODE_THR:  o_pix = (i_pix >= i_threshold) ? '1 : '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axis_video_pixel_proc.sv
`default_nettype none
// ============================================================================
// Module  : axis_video_pixel_proc
// Brief   : Two-stage AXIS pixel processor with frame-latched mode and EOL check.
// Revision: 1.0 - initial release
// ============================================================================
module axis_video_pixel_proc
    import axis_video_pkg::*;
#(
    parameter int CHANNELS    = c_DEFAULT_CHANNELS,
    parameter int CW          = c_DEFAULT_CW,
    parameter int LINE_PIXELS = 640,
    parameter int ERRW        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mode,
    input  logic [CW:0]               offset,
    input  logic [CW-1:0]             threshold,
    axis_video_pixel_proc_if.slave    s_axis,
    axis_video_pixel_proc_if.master   m_axis,
    output logic                      err_eol,
    output logic [ERRW-1:0]           err_count
);

    localparam int DATA_WIDTH = CHANNELS * CW;
    localparam int c_CNT_W    = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_PIX = c_CNT_W'(LINE_PIXELS - 1);

    logic                  w_adv;
    logic                  w_accept;
    mode_e                 w_eff_mode;
    logic [CW:0]           w_eff_offset;
    logic [CW-1:0]         w_eff_thr;
    logic [DATA_WIDTH-1:0] w_result;
    logic [c_CNT_W-1:0]    w_cur;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic                  w_at_end;
    logic                  w_err;

    mode_e                 r_mode;
    logic [CW:0]           r_offset;
    logic [CW-1:0]         r_threshold;
    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_last;
    logic                  r_s1_user;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_last;
    logic                  r_m_user;
    logic [c_CNT_W-1:0]    r_pix_cnt;
    logic                  r_err_eol;
    logic [ERRW-1:0]       r_err_count;

    assign w_adv          = !r_m_valid || m_axis.tready;
    assign w_accept       = s_axis.tvalid && w_adv;
    assign s_axis.tready  = w_adv;

    // A start-of-frame beat is itself processed with the settings it latches.
    always_comb begin
        w_eff_mode   = r_mode;
        w_eff_offset = r_offset;
        w_eff_thr    = r_threshold;
        if (s_axis.tuser) begin
            w_eff_mode   = mode_e'(mode);
            w_eff_offset = offset;
            w_eff_thr    = threshold;
        end
    end

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
            axis_video_chan_op #(.CW(CW)) u_chan_op (
                .i_pix       (s_axis.tdata[k*CW +: CW]),
                .i_mode      (w_eff_mode),
                .i_offset    (w_eff_offset),
                .i_threshold (w_eff_thr),
                .o_pix       (w_result[k*CW +: CW])
            );
        end
    endgenerate

    always_comb begin
        w_cur     = s_axis.tuser ? '0 : r_pix_cnt;
        w_at_end  = (w_cur == c_LAST_PIX);
        w_err     = s_axis.tlast ? !w_at_end : w_at_end;
        w_cnt_nxt = (s_axis.tlast || w_at_end) ? '0 : w_cur + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode      <= MODE_PASS;
            r_offset    <= '0;
            r_threshold <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_last   <= 1'b0;
            r_s1_user   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_last    <= 1'b0;
            r_m_user    <= 1'b0;
            r_pix_cnt   <= '0;
            r_err_eol   <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_adv) begin
                r_s1_valid <= s_axis.tvalid;
                r_s1_data  <= w_result;
                r_s1_last  <= s_axis.tlast;
                r_s1_user  <= s_axis.tuser;
                r_m_valid  <= r_s1_valid;
                r_m_data   <= r_s1_data;
                r_m_last   <= r_s1_last;
                r_m_user   <= r_s1_user;
            end
            if (w_accept && s_axis.tuser) begin
                r_mode      <= mode_e'(mode);
                r_offset    <= offset;
                r_threshold <= threshold;
            end
            if (w_accept)
                r_pix_cnt <= w_cnt_nxt;
            r_err_eol <= w_accept && w_err;
            if (w_accept && w_err && (r_err_count != {ERRW{1'b1}}))
                r_err_count <= r_err_count + 1'b1;
        end
    end

    assign m_axis.tvalid = r_m_valid;
    assign m_axis.tdata  = r_m_data;
    assign m_axis.tlast  = r_m_last;
    assign m_axis.tuser  = r_m_user;
    assign err_eol       = r_err_eol;
    assign err_count     = r_err_count;

endmodule
`default_nettype wire

// File: doc/axis_video_pixel_proc.md
AXIS_VIDEO_PIXEL_PROC -- requirements
Module: axis_video_pixel_proc

Interface
REQ-001 SHALL have parameter CHANNELS, default 3, colour channels per pixel.
REQ-002 SHALL have parameter CW, default 8, bits per channel; DATA_WIDTH = CHANNELS*CW, derived, not a parameter.
REQ-003 SHALL have parameter LINE_PIXELS, default 640, expected beats per line.
REQ-004 SHALL have parameter ERRW, default 16, error counter width.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port mode  input  2  0 pass, 1 invert, 2 offset, 3 threshold.
REQ-008 SHALL have port offset  input  CW+1  signed brightness offset for mode 2.
REQ-009 SHALL have port threshold  input  CW  compare level for mode 3.
REQ-010 SHALL have ports s_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  DATA_WIDTH/1/1/1/1  slave stream; tuser = start of frame.
REQ-011 SHALL have ports m_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  DATA_WIDTH/1/1/1/1  master stream.
REQ-012 SHALL have port err_eol  output  1  one-cycle pulse on a line-length violation.
REQ-013 SHALL have port err_count  output  ERRW  saturating count of violations.

Function
REQ-014 Beat transfer: a beat SHALL transfer only when tvalid and tready are both high in the same cycle.
REQ-015 Pipeline: two register stages (compute, output) with a common enable adv = !m_axis_tvalid | m_axis_tready.
REQ-016 s_axis_tready SHALL equal adv, giving full throughput and latency of exactly 2 cycles when m_axis_tready is held high.
REQ-017 Stall behaviour: while m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs SHALL hold stable.
REQ-018 tlast and tuser SHALL travel with their beat unchanged.
REQ-019 Mode latching: the active mode, offset and threshold SHALL be latched on an accepted beat with tuser=1.
REQ-020 Mode changes mid-frame SHALL be ignored until the next tuser beat; after reset the active mode SHALL be 0.
REQ-021 Per-channel arithmetic, mode 0: out = in.
REQ-022 Mode 1: out = (2^CW-1) - in.
REQ-023 Mode 2: out = in + offset, computed in CW+2 bits and clamped to [0, 2^CW-1].
REQ-024 Mode 3: out = 2^CW-1 if in >= threshold, else 0.
REQ-025 Channel packing: channel k SHALL occupy bits [k*CW +: CW] on both streams.
REQ-026 Line counting: a pixel counter SHALL increment on each accepted beat, clear to 0 on an accepted tlast, and clear to 0 on an accepted tuser (tuser beat counts as pixel 0).
REQ-027 Early EOL: an accepted tlast with counter != LINE_PIXELS-1 SHALL pulse err_eol; the counter SHALL still clear.
REQ-028 Late EOL: an accepted beat at counter == LINE_PIXELS-1 without tlast SHALL pulse err_eol and the counter SHALL wrap to 0.
REQ-029 Violations SHALL NOT alter the data stream.
REQ-030 err_eol SHALL assert the cycle after the offending beat is accepted.
REQ-031 err_count SHALL increment on each err_eol pulse and saturate at 2^ERRW-1.
REQ-032 Simultaneous tuser and tlast on one beat: the counter SHALL clear, the tlast check SHALL apply with counter 0, and the mode SHALL latch.

Reset
REQ-033 On reset, m_axis_tvalid, m_axis_tlast, m_axis_tuser, err_eol, err_count, the pixel counter and the active mode SHALL be 0.
REQ-034 m_axis_tdata SHALL reset to 0.
REQ-035 s_axis_tready SHALL be 1 after reset is released.
REQ-036 Reset asserted mid-frame SHALL discard in-flight beats with no output transfer.

Structure
REQ-037 Package axis_video_pkg SHALL hold the mode encodings (MODE_PASS, MODE_INV, MODE_OFS, MODE_THR) and the default CW and CHANNELS constants.
REQ-038 One sub-module, axis_video_chan_op, SHALL implement the per-channel arithmetic combinationally and be instantiated CHANNELS times.

Verification
REQ-039 Reset, then mode 1, tuser beat 0x102030, m_ready=1 -> m_tdata 0xEFDFCF exactly 2 cycles later with tuser=1.
REQ-040 Mode 2, offset +40, pixel 0xF00A05 -> 0xFF322D; offset -20, pixel 0x0A1464 -> 0x000050 (clamped).
REQ-041 640-beat line in mode 0 with m_ready toggling 50% -> output data equals input in order, no beat lost or duplicated, err_count 0.
REQ-042 Line with tlast on beat 100 -> single err_eol pulse and err_count=1; the next 640-beat line -> no error.
REQ-043 Mode switched 0->3 at pixel 5 mid-frame -> rest of frame passes unchanged; threshold applies from the next tuser beat (0x7F80FF, thr 0x80 -> 0x00FFFF).
REQ-044 Reset asserted with 2 beats in flight -> m_tvalid=0 immediately, err_count=0, the first post-reset beat emerges correctly.
